// File: rtl/csaddress_branch_logic.sv
// Control-branch-logic stage of the microsequencer. Produces the next-select
// code, jump target and incremented address for the control-store address
// register, and keeps the PSR condition flags. While a memory access is
// outstanding it makes the sequencer reload its current address, but only for
// a bounded number of cycles. A sticky flag records any wait that ran out.
module csaddress_branch_logic #(
  parameter int DATAWIDTH_CSADDRESS = 11,
  parameter int DATAWIDTH_CBL       = 2,
  parameter int DATAWIDTH_COND      = 3,
  parameter int DATAWIDTH_FLAGS     = 4,
  parameter int WAIT_TIMEOUT        = 16
) (
  input  logic                           CSADDRESS_CLOCK_50,
  input  logic                           CSADDRESS_ResetInHigh_In,
  input  logic [DATAWIDTH_CSADDRESS-1:0] CSBRANCH_CSAddress_InBus,
  input  logic [DATAWIDTH_COND-1:0]      CSBRANCH_Cond_InBus,
  input  logic [DATAWIDTH_CSADDRESS-1:0] CSBRANCH_JumpAddr_InBus,
  input  logic                           CSBRANCH_IR13_In,
  input  logic                           CSBRANCH_SetCC_In,
  input  logic [DATAWIDTH_FLAGS-1:0]     CSBRANCH_ALUFlags_InBus,
  input  logic                           CSBRANCH_MemReq_In,
  input  logic                           CSBRANCH_MemAck_In,
  output logic [DATAWIDTH_CBL-1:0]       CSBRANCH_Tipo_OutBus,
  output logic [DATAWIDTH_CSADDRESS-1:0] CSBRANCH_JumpAddress_OutBus,
  output logic [DATAWIDTH_CSADDRESS-1:0] CSBRANCH_CSAI_OutBus,
  output logic [DATAWIDTH_FLAGS-1:0]     CSBRANCH_PSR_OutBus,
  output logic                           CSBRANCH_Stall_Out,
  output logic                           CSBRANCH_MemTimeout_Out
);

  localparam int WAITCNT_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [WAITCNT_W-1:0] WAIT_LAST = WAITCNT_W'(WAIT_TIMEOUT - 1);

  localparam logic [DATAWIDTH_CBL-1:0] TIPO_NEXT   = DATAWIDTH_CBL'(0);
  localparam logic [DATAWIDTH_CBL-1:0] TIPO_JUMP   = DATAWIDTH_CBL'(1);
  localparam logic [DATAWIDTH_CBL-1:0] TIPO_DECODE = DATAWIDTH_CBL'(2);

  logic [DATAWIDTH_FLAGS-1:0] psrReg;
  logic [WAITCNT_W-1:0]       waitCnt;
  logic                       memTimeoutReg;
  logic                       memPending;
  logic                       waitExpired;
  logic                       stall;
  logic                       condTaken;

  // Flags are ordered {n,z,v,c}.
  logic flagN, flagZ, flagV, flagC;
  assign flagN = psrReg[DATAWIDTH_FLAGS-1];
  assign flagZ = psrReg[DATAWIDTH_FLAGS-2];
  assign flagV = psrReg[DATAWIDTH_FLAGS-3];
  assign flagC = psrReg[DATAWIDTH_FLAGS-4];

  // An access is pending until acked. The wait is released on the cycle the
  // counter reaches its last value, so a stall lasts at most WAIT_TIMEOUT-1
  // cycles.
  assign memPending  = CSBRANCH_MemReq_In & ~CSBRANCH_MemAck_In;
  assign waitExpired = (waitCnt == WAIT_LAST);
  assign stall       = memPending & ~waitExpired & ~CSADDRESS_ResetInHigh_In;

  assign CSBRANCH_Stall_Out          = stall;
  assign CSBRANCH_CSAI_OutBus        = CSBRANCH_CSAddress_InBus + DATAWIDTH_CSADDRESS'(1);
  assign CSBRANCH_JumpAddress_OutBus = stall ? CSBRANCH_CSAddress_InBus : CSBRANCH_JumpAddr_InBus;
  assign CSBRANCH_PSR_OutBus         = psrReg;
  assign CSBRANCH_MemTimeout_Out     = memTimeoutReg;

  // Evaluate the COND field against the flags as they stood at the start of the cycle.
  always_comb begin
    condTaken = 1'b0;
    case (CSBRANCH_Cond_InBus)
      3'b001:  condTaken = flagN;
      3'b010:  condTaken = flagZ;
      3'b011:  condTaken = flagV;
      3'b100:  condTaken = flagC;
      3'b101:  condTaken = CSBRANCH_IR13_In;
      3'b110:  condTaken = 1'b1;
      default: condTaken = 1'b0;
    endcase
  end

  // Select the next-address source: a stall forces a self-jump, otherwise COND decides.
  always_comb begin
    CSBRANCH_Tipo_OutBus = TIPO_NEXT;
    if (CSADDRESS_ResetInHigh_In) begin
      CSBRANCH_Tipo_OutBus = TIPO_NEXT;
    end else if (stall) begin
      CSBRANCH_Tipo_OutBus = TIPO_JUMP;
    end else if (CSBRANCH_Cond_InBus == 3'b111) begin
      CSBRANCH_Tipo_OutBus = TIPO_DECODE;
    end else if (condTaken) begin
      CSBRANCH_Tipo_OutBus = TIPO_JUMP;
    end
  end

  // Update PSR on unstalled SetCC microwords only.
  always_ff @(posedge CSADDRESS_CLOCK_50 or posedge CSADDRESS_ResetInHigh_In) begin
    if (CSADDRESS_ResetInHigh_In) begin
      psrReg <= '0;
    end else if (CSBRANCH_SetCC_In && !stall) begin
      psrReg <= CSBRANCH_ALUFlags_InBus;
    end
  end

  // Count stalled cycles of the current access; any ack or idle cycle restarts it,
  // and an expired wait restarts it while latching the sticky timeout flag.
  always_ff @(posedge CSADDRESS_CLOCK_50 or posedge CSADDRESS_ResetInHigh_In) begin
    if (CSADDRESS_ResetInHigh_In) begin
      waitCnt       <= '0;
      memTimeoutReg <= 1'b0;
    end else if (!memPending) begin
      waitCnt <= '0;
    end else if (stall) begin
      waitCnt <= waitCnt + WAITCNT_W'(1);
    end else begin
      waitCnt       <= '0;
      memTimeoutReg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_csaddress_branch_logic.sv
// Directed bench for csaddress_branch_logic. A driver applies one vector per
// cycle and queues its expected outputs; a monitor pops and compares on the
// falling edge of every cycle that has a queued expectation.
module tb_csaddress_branch_logic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] csAddr = '0;
  logic [2:0]  cond = '0;
  logic [10:0] jumpAddr = '0;
  logic        ir13 = 1'b0;
  logic        setCC = 1'b0;
  logic [3:0]  aluFlags = '0;
  logic        memReq = 1'b0;
  logic        memAck = 1'b0;
  logic [1:0]  tipo;
  logic [10:0] jumpAddress;
  logic [10:0] csai;
  logic [3:0]  psr;
  logic        stall;
  logic        memTimeout;

  typedef struct {
    string       nm;
    logic [1:0]  tipo;
    logic [10:0] ja;
    logic [10:0] csai;
    logic [3:0]  psr;
    logic        stall;
    logic        tmo;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  bit   driverDone = 1'b0;

  csaddress_branch_logic #(
    .DATAWIDTH_CSADDRESS(11),
    .DATAWIDTH_CBL(2),
    .DATAWIDTH_COND(3),
    .DATAWIDTH_FLAGS(4),
    .WAIT_TIMEOUT(16)
  ) dut (
    .CSADDRESS_CLOCK_50(clk),
    .CSADDRESS_ResetInHigh_In(rst),
    .CSBRANCH_CSAddress_InBus(csAddr),
    .CSBRANCH_Cond_InBus(cond),
    .CSBRANCH_JumpAddr_InBus(jumpAddr),
    .CSBRANCH_IR13_In(ir13),
    .CSBRANCH_SetCC_In(setCC),
    .CSBRANCH_ALUFlags_InBus(aluFlags),
    .CSBRANCH_MemReq_In(memReq),
    .CSBRANCH_MemAck_In(memAck),
    .CSBRANCH_Tipo_OutBus(tipo),
    .CSBRANCH_JumpAddress_OutBus(jumpAddress),
    .CSBRANCH_CSAI_OutBus(csai),
    .CSBRANCH_PSR_OutBus(psr),
    .CSBRANCH_Stall_Out(stall),
    .CSBRANCH_MemTimeout_Out(memTimeout)
  );

  always #5 clk = ~clk;

  // Apply one vector just after the rising edge and queue what it must produce.
  task automatic vec(input string nm, input logic r, input logic [2:0] c,
                     input logic [10:0] cs, input logic [10:0] ja, input logic ir,
                     input logic sc, input logic [3:0] fl, input logic mr, input logic ma,
                     input logic [1:0] eTipo, input logic [10:0] eJa, input logic [10:0] eCsai,
                     input logic [3:0] ePsr, input logic eStall, input logic eTmo);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; cond = c; csAddr = cs; jumpAddr = ja; ir13 = ir;
    setCC = sc; aluFlags = fl; memReq = mr; memAck = ma;
    e.nm = nm; e.tipo = eTipo; e.ja = eJa; e.csai = eCsai;
    e.psr = ePsr; e.stall = eStall; e.tmo = eTmo;
    expQ.push_back(e);
  endtask

  // Monitor: the DUT presents a full output set every cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      testsRun++;
      if (tipo !== e.tipo || jumpAddress !== e.ja || csai !== e.csai ||
          psr !== e.psr || stall !== e.stall || memTimeout !== e.tmo) begin
        testsFailed++;
        $display("FAIL %s: got tipo=%h ja=%h csai=%h psr=%h stall=%b tmo=%b, expected tipo=%h ja=%h csai=%h psr=%h stall=%b tmo=%b",
                 e.nm, tipo, jumpAddress, csai, psr, stall, memTimeout,
                 e.tipo, e.ja, e.csai, e.psr, e.stall, e.tmo);
      end
    end
  end

  initial begin
    //    name            rst cond    cs      ja      ir sc fl       mr ma   tipo   ja      csai    psr     st tmo
    vec("reset",          1, 3'b000, 11'h010, 11'h000, 0, 0, 4'h0,   0, 0,   2'b00, 11'h000, 11'h011, 4'h0, 0, 0);
    vec("reset_memreq",   1, 3'b110, 11'h020, 11'h055, 0, 1, 4'hF,   1, 0,   2'b00, 11'h055, 11'h021, 4'h0, 0, 0);
    vec("next",           0, 3'b000, 11'h010, 11'h000, 0, 0, 4'h0,   0, 0,   2'b00, 11'h000, 11'h011, 4'h0, 0, 0);
    vec("csai_wrap",      0, 3'b000, 11'h7FF, 11'h000, 0, 0, 4'h0,   0, 0,   2'b00, 11'h000, 11'h000, 4'h0, 0, 0);
    vec("z_old_psr",      0, 3'b010, 11'h100, 11'h123, 0, 1, 4'h4,   0, 0,   2'b00, 11'h123, 11'h101, 4'h0, 0, 0);
    vec("z_taken",        0, 3'b010, 11'h101, 11'h123, 0, 0, 4'h0,   0, 0,   2'b01, 11'h123, 11'h102, 4'h4, 0, 0);
    vec("n_not_taken",    0, 3'b001, 11'h102, 11'h123, 0, 0, 4'h0,   0, 0,   2'b00, 11'h123, 11'h103, 4'h4, 0, 0);
    vec("v_not_taken",    0, 3'b011, 11'h103, 11'h124, 0, 0, 4'h0,   0, 0,   2'b00, 11'h124, 11'h104, 4'h4, 0, 0);
    vec("c_not_taken",    0, 3'b100, 11'h104, 11'h125, 0, 0, 4'h0,   0, 0,   2'b00, 11'h125, 11'h105, 4'h4, 0, 0);
    vec("decode",         0, 3'b111, 11'h105, 11'h126, 0, 0, 4'h0,   0, 0,   2'b10, 11'h126, 11'h106, 4'h4, 0, 0);
    vec("ir13_set",       0, 3'b101, 11'h106, 11'h127, 1, 0, 4'h0,   0, 0,   2'b01, 11'h127, 11'h107, 4'h4, 0, 0);
    vec("ir13_clr",       0, 3'b101, 11'h107, 11'h128, 0, 0, 4'h0,   0, 0,   2'b00, 11'h128, 11'h108, 4'h4, 0, 0);
    vec("uncond",         0, 3'b110, 11'h108, 11'h129, 0, 0, 4'h0,   0, 0,   2'b01, 11'h129, 11'h109, 4'h4, 0, 0);
    vec("setcc_nvc",      0, 3'b000, 11'h109, 11'h000, 0, 1, 4'hB,   0, 0,   2'b00, 11'h000, 11'h10A, 4'h4, 0, 0);
    vec("n_taken",        0, 3'b001, 11'h10A, 11'h200, 0, 0, 4'h0,   0, 0,   2'b01, 11'h200, 11'h10B, 4'hB, 0, 0);
    vec("v_taken",        0, 3'b011, 11'h10B, 11'h201, 0, 0, 4'h0,   0, 0,   2'b01, 11'h201, 11'h10C, 4'hB, 0, 0);
    vec("c_taken",        0, 3'b100, 11'h10C, 11'h202, 0, 0, 4'h0,   0, 0,   2'b01, 11'h202, 11'h10D, 4'hB, 0, 0);
    vec("z_not_taken",    0, 3'b010, 11'h10D, 11'h203, 0, 0, 4'h0,   0, 0,   2'b00, 11'h203, 11'h10E, 4'hB, 0, 0);
    // Three stalled cycles, then ack: PSR held while stalled, updated at the ack edge.
    for (int i = 0; i < 3; i++)
      vec("mem_stall",    0, 3'b110, 11'h040, 11'h200, 0, 1, 4'h1,   1, 0,   2'b01, 11'h040, 11'h041, 4'hB, 1, 0);
    vec("mem_ack",        0, 3'b110, 11'h040, 11'h200, 0, 1, 4'h1,   1, 1,   2'b01, 11'h200, 11'h041, 4'hB, 0, 0);
    vec("psr_after_ack",  0, 3'b000, 11'h041, 11'h000, 0, 0, 4'h0,   0, 0,   2'b00, 11'h000, 11'h042, 4'h1, 0, 0);
    vec("ack_first",      0, 3'b000, 11'h042, 11'h000, 0, 0, 4'h0,   1, 1,   2'b00, 11'h000, 11'h043, 4'h1, 0, 0);
    vec("ack_no_req",     0, 3'b010, 11'h043, 11'h0AA, 0, 0, 4'h0,   0, 1,   2'b00, 11'h0AA, 11'h044, 4'h1, 0, 0);
    // No ack ever: 15 stalled cycles, release on the 16th, flag visible afterwards.
    for (int i = 0; i < 15; i++)
      vec("tmo_stall",    0, 3'b110, 11'h050, 11'h300, 0, 1, 4'hF,   1, 0,   2'b01, 11'h050, 11'h051, 4'h1, 1, 0);
    vec("tmo_release",    0, 3'b110, 11'h050, 11'h300, 0, 1, 4'hF,   1, 0,   2'b01, 11'h300, 11'h051, 4'h1, 0, 0);
    vec("tmo_sticky",     0, 3'b000, 11'h051, 11'h000, 0, 0, 4'h0,   0, 0,   2'b00, 11'h000, 11'h052, 4'hF, 0, 1);
    vec("tmo_hold",       0, 3'b000, 11'h052, 11'h000, 0, 0, 4'h0,   0, 0,   2'b00, 11'h000, 11'h053, 4'hF, 0, 1);
    // Reset in the middle of a stall.
    vec("stall2_a",       0, 3'b110, 11'h060, 11'h3AA, 0, 0, 4'h0,   1, 0,   2'b01, 11'h060, 11'h061, 4'hF, 1, 1);
    vec("stall2_b",       0, 3'b110, 11'h060, 11'h3AA, 0, 0, 4'h0,   1, 0,   2'b01, 11'h060, 11'h061, 4'hF, 1, 1);
    vec("rst_midstall",   1, 3'b110, 11'h060, 11'h3AA, 0, 0, 4'h0,   1, 0,   2'b00, 11'h3AA, 11'h061, 4'h0, 0, 0);
    vec("after_rst",      0, 3'b110, 11'h060, 11'h3AA, 0, 0, 4'h0,   1, 0,   2'b01, 11'h060, 11'h061, 4'h0, 1, 0);
    vec("idle",           0, 3'b000, 11'h061, 11'h000, 0, 0, 4'h0,   0, 0,   2'b00, 11'h000, 11'h062, 4'h0, 0, 0);
    driverDone = 1'b1;
  end

  // Bounded wait for the monitor to drain the queue, then report.
  initial begin
    int budget;
    budget = 0;
    while (!(driverDone && expQ.size() == 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    #1;
    if (expQ.size() != 0 || !driverDone) begin
      testsRun++;
      testsFailed++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
